data_mem_responder: RTL and testbench



---
 rtl/data_mem_if.sv | 32 +++
 rtl/data_mem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the core (master) and the
// data memory responder (slave).
//   clk_enable            tick qualifier shared by core and responder
//   rst_ready             responder finished post-reset zero-fill
//   r_en/r_addr/r_mode    read request (byte address, 00 B, 01 H, 10 W)
//   r_data                registered right-justified read data
//   w_en/w_addr/w_data/w_mode  write request
//   fault/fault_addr      sticky access fault and first faulting address
interface data_mem_if;
    logic        clk_enable;
    logic        rst_ready;
    logic        r_en;
    logic [31:0] r_addr;
    logic [1:0]  r_mode;
    logic [31:0] r_data;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [1:0]  w_mode;
    logic        fault;
    logic [31:0] fault_addr;

    modport master (
        output clk_enable, r_en, r_addr, r_mode, w_en, w_addr, w_data, w_mode,
        input  rst_ready, r_data, fault, fault_addr
    );

    modport slave (
        input  clk_enable, r_en, r_addr, r_mode, w_en, w_addr, w_data, w_mode,
        output rst_ready, r_data, fault, fault_addr
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised byte-lane RAM answering the core's
// load/store requests with a one-tick registered read.
//   clk    system clock
//   rst_n  synchronous active-low reset; restarts the zero-fill
//   bus    data_mem_if.slave (requests in, r_data/fault/rst_ready out)
// After reset the RAM is zero-filled one word per clock (regardless of
// clk_enable); rst_ready rises on the edge that clears the last word.
module data_mem_responder #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    data_mem_if.slave   bus
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [0:DEPTH-1];

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    rdy_q, rdy_d;
    logic [31:0]             r_data_q;
    logic                    fault_q;
    logic [31:0]             fault_addr_q;

    // Access legality: bad mode, misalignment, below base, or beyond capacity.
    // The 33-bit subtraction exposes a borrow when addr is below BASE_ADDR.
    function automatic logic is_illegal(input logic [31:0] addr, input logic [1:0] mode);
        logic [32:0] off;
        logic        bad;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        bad = 1'b0;
        case (mode)
            2'b00:   bad = 1'b0;
            2'b01:   bad = off[0];
            2'b10:   bad = (off[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (off[32] || (off[31:ADDR_WIDTH+2] != '0)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    // Right-justify the addressed byte/half/word of a RAM word.
    function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] mode,
                                            input logic [1:0] lane);
        logic [31:0] res;
        case (mode)
            2'b00:   res = {24'h00_0000, word[8*lane +: 8]};
            2'b01:   res = lane[1] ? {16'h0000, word[31:16]} : {16'h0000, word[15:0]};
            2'b10:   res = word;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

    logic [31:0]           r_off_s, w_off_s;
    logic [ADDR_WIDTH-1:0] r_idx_s;
    logic                  r_bad_s, w_bad_s;
    logic                  r_act_s, w_act_s;

    // Address decode for both request channels.
    always_comb begin
        r_off_s = bus.r_addr - BASE_ADDR;
        w_off_s = bus.w_addr - BASE_ADDR;
        r_idx_s = r_off_s[ADDR_WIDTH+1:2];
        r_bad_s = is_illegal(bus.r_addr, bus.r_mode);
        w_bad_s = is_illegal(bus.w_addr, bus.w_mode);
        r_act_s = (state_q == ST_READY) && bus.clk_enable && bus.r_en;
        w_act_s = (state_q == ST_READY) && bus.clk_enable && bus.w_en;
    end

    // FSM state, clear counter and ready flag registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= rdy_d;
        end
    end

    // Next-state logic: walk the counter through every word, then go ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdy_d   = rdy_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_READY;
                    rdy_d   = 1'b1;
                end else begin
                    rdy_d   = 1'b0;
                end
            end
            ST_READY: begin
                rdy_d = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                rdy_d   = 1'b0;
            end
        endcase
    end

    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_idx_s;
    logic [3:0]            wr_be_s;
    logic [31:0]           wr_data_s;

    // Single write port: zero-fill in CLEAR, legal stores in READY.
    // Narrow store data is replicated across lanes; byte enables pick the lane.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = cnt_q;
        wr_be_s   = 4'h0;
        wr_data_s = 32'h0000_0000;
        if (state_q == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_be_s   = 4'hF;
        end else if (rst_n && w_act_s && !w_bad_s) begin
            wr_en_s  = 1'b1;
            wr_idx_s = w_off_s[ADDR_WIDTH+1:2];
            case (bus.w_mode)
                2'b00: begin
                    wr_be_s   = 4'b0001 << w_off_s[1:0];
                    wr_data_s = {4{bus.w_data[7:0]}};
                end
                2'b01: begin
                    wr_be_s   = w_off_s[1] ? 4'b1100 : 4'b0011;
                    wr_data_s = {2{bus.w_data[15:0]}};
                end
                2'b10: begin
                    wr_be_s   = 4'hF;
                    wr_data_s = bus.w_data;
                end
                default: begin
                    wr_en_s   = 1'b0;
                end
            endcase
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Byte-enabled RAM write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be_s[i]) begin
                    mem[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                end
            end
        end
    end

    // Registered read port; reading alongside the write gives pre-write data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_q <= 32'h0000_0000;
        end else if (state_q != ST_READY) begin
            r_data_q <= 32'h0000_0000;
        end else if (r_act_s) begin
            r_data_q <= r_bad_s ? 32'h0000_0000
                                : extract(mem[r_idx_s], bus.r_mode, r_off_s[1:0]);
        end
    end

    // Sticky fault; first faulting address wins, write beats read on a tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0000_0000;
        end else if ((w_act_s && w_bad_s) || (r_act_s && r_bad_s)) begin
            fault_q <= 1'b1;
            if (!fault_q) begin
                fault_addr_q <= (w_act_s && w_bad_s) ? bus.w_addr : bus.r_addr;
            end
        end
    end

    assign bus.rst_ready  = rdy_q;
    assign bus.r_data     = r_data_q;
    assign bus.fault      = fault_q;
    assign bus.fault_addr = fault_addr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   n;

    data_mem_if bus ();

    data_mem_responder #(
        .ADDR_WIDTH (10),
        .BASE_ADDR  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic re, input logic [31:0] ra, input logic [1:0] rm,
                      input logic we, input logic [31:0] wa, input logic [31:0] wd,
                      input logic [1:0] wm);
        bus.clk_enable = 1'b1;
        bus.r_en = re; bus.r_addr = ra; bus.r_mode = rm;
        bus.w_en = we; bus.w_addr = wa; bus.w_data = wd; bus.w_mode = wm;
        tick();
        bus.r_en = 1'b0;
        bus.w_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        op(1'b0, 32'h0, 2'b10, 1'b1, a, d, m);
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] m);
        op(1'b1, a, m, 1'b0, 32'h0, 32'h0, 2'b10);
    endtask

    // Count edges from rst_n release until rst_ready, bounded.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!bus.rst_ready && cnt < 3000) begin
            tick();
            cnt++;
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        bus.clk_enable = 1'b0;
        bus.r_en = 1'b0; bus.r_addr = 32'h0; bus.r_mode = 2'b10;
        bus.w_en = 1'b0; bus.w_addr = 32'h0; bus.w_data = 32'h0; bus.w_mode = 2'b10;
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_ready_in_reset", {31'h0, bus.rst_ready}, 32'h0);
        chk("r_data_in_reset",    bus.r_data,              32'h0);
        chk("fault_in_reset",     {31'h0, bus.fault},     32'h0);
        chk("fault_addr_in_reset", bus.fault_addr,        32'h0);

        rst_n = 1'b1;
        wait_ready(n);
        chk("clear_len", n, 32'd1024);
        rd(32'h0000_0FFC, 2'b10);
        chk("rd_last_word_zero", bus.r_data, 32'h0);

        // Write beats read in fault priority on the same tick.
        op(1'b1, 32'h0000_0003, 2'b10, 1'b1, 32'h0000_0005, 32'h1234_5678, 2'b10);
        chk("tie_fault", {31'h0, bus.fault}, 32'h1);
        chk("tie_fault_addr", bus.fault_addr, 32'h0000_0005);
        chk("tie_r_data", bus.r_data, 32'h0);

        // Last-word boundary is legal.
        wr(32'h0000_0FFC, 32'hCAFE_F00D, 2'b10);
        rd(32'h0000_0FFC, 2'b10);
        chk("rd_last_word", bus.r_data, 32'hCAFE_F00D);

        // Byte and half extraction, little-endian.
        wr(32'h0000_0010, 32'hDEAD_BEEF, 2'b10);
        rd(32'h0000_0010, 2'b00); chk("lb_10", bus.r_data, 32'h0000_00EF);
        rd(32'h0000_0011, 2'b00); chk("lb_11", bus.r_data, 32'h0000_00BE);
        rd(32'h0000_0012, 2'b00); chk("lb_12", bus.r_data, 32'h0000_00AD);
        rd(32'h0000_0013, 2'b00); chk("lb_13", bus.r_data, 32'h0000_00DE);
        rd(32'h0000_0010, 2'b01); chk("lh_10", bus.r_data, 32'h0000_BEEF);
        rd(32'h0000_0012, 2'b01); chk("lh_12", bus.r_data, 32'h0000_DEAD);

        // Byte-lane stores.
        wr(32'h0000_0020, 32'h1122_3344, 2'b10);
        wr(32'h0000_0022, 32'h0000_00AA, 2'b00);
        rd(32'h0000_0020, 2'b10); chk("sb_merge", bus.r_data, 32'h11AA_3344);
        wr(32'h0000_0020, 32'h0000_BBCC, 2'b01);
        rd(32'h0000_0020, 2'b10); chk("sh_merge", bus.r_data, 32'h11AA_BBCC);

        // Read-before-write on the same word.
        wr(32'h0000_0030, 32'h0102_0304, 2'b10);
        op(1'b1, 32'h0000_0030, 2'b10, 1'b1, 32'h0000_0030, 32'h5566_7788, 2'b10);
        chk("rbw_old", bus.r_data, 32'h0102_0304);
        rd(32'h0000_0030, 2'b10); chk("rbw_new", bus.r_data, 32'h5566_7788);

        // clk_enable low: r_data holds and memory is untouched.
        bus.clk_enable = 1'b0;
        bus.r_en = 1'b1; bus.r_addr = 32'h0000_0010; bus.r_mode = 2'b10;
        bus.w_en = 1'b1; bus.w_addr = 32'h0000_0030; bus.w_data = 32'hFFFF_FFFF; bus.w_mode = 2'b10;
        tick(); tick();
        bus.r_en = 1'b0; bus.w_en = 1'b0;
        chk("ce_low_hold", bus.r_data, 32'h5566_7788);
        rd(32'h0000_0030, 2'b10); chk("ce_low_no_write", bus.r_data, 32'h5566_7788);

        // Sticky fault: first address kept, illegal accesses change nothing.
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_ready(n);
        chk("clear_len_2", n, 32'd1024);
        chk("fault_cleared", {31'h0, bus.fault}, 32'h0);
        wr(32'h0000_0040, 32'h0A0B_0C0D, 2'b10);
        rd(32'h0000_0040, 2'b10);
        wr(32'h0000_0041, 32'h0000_FFFF, 2'b01);
        chk("sh_mis_fault", {31'h0, bus.fault}, 32'h1);
        chk("sh_mis_addr", bus.fault_addr, 32'h0000_0041);
        rd(32'h0000_0042, 2'b10);
        chk("lw_mis_rdata", bus.r_data, 32'h0);
        chk("lw_mis_addr", bus.fault_addr, 32'h0000_0041);
        wr(32'h0000_1000, 32'h7777_7777, 2'b10);
        chk("sw_oor_addr", bus.fault_addr, 32'h0000_0041);
        rd(32'h0000_0040, 2'b10); chk("mis_mem_same", bus.r_data, 32'h0A0B_0C0D);
        rd(32'h0000_0000, 2'b10); chk("oor_no_alias", bus.r_data, 32'h0);
        rd(32'h0000_0040, 2'b11); chk("mode11_rdata", bus.r_data, 32'h0);

        // Reset mid-operation and mid-clear restarts the zero-fill.
        wr(32'h0000_0010, 32'h1357_9BDF, 2'b10);
        rst_n = 1'b0; tick();
        chk("rst_drops_ready", {31'h0, bus.rst_ready}, 32'h0);
        chk("rst_clears_fault", {31'h0, bus.fault}, 32'h0);
        rst_n = 1'b1;
        bus.clk_enable = 1'b1; bus.r_en = 1'b1; bus.r_addr = 32'h0000_0040; bus.r_mode = 2'b10;
        repeat (200) tick();
        chk("clear_ignores_read", bus.r_data, 32'h0);
        chk("mid_clear_not_ready", {31'h0, bus.rst_ready}, 32'h0);
        bus.r_en = 1'b0;
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        wait_ready(n);
        chk("clear_len_3", n, 32'd1024);
        rd(32'h0000_0010, 2'b10); chk("word10_zeroed", bus.r_data, 32'h0);
        rd(32'h0000_0040, 2'b10); chk("word40_zeroed", bus.r_data, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
